// File: rtl/ide_pkg.sv
// Shared types for the IDE sector FIFO transfer engine.
package ide_pkg;

    localparam int SECTOR_WORDS_DEF = 256;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        WR_LO,
        WR_HI,
        WR_PULSE,
        WR_GAP,
        RD_CHECK,
        RD_SETTLE,
        RD_LO,
        RD_HI,
        RD_PULSE,
        RD_GAP,
        DONE
    } xfer_state_t;

endpackage

// File: rtl/ide_fifo_xfer_if.sv
// Byte-stream, FIFO and control signals of the IDE transfer engine.
interface ide_fifo_xfer_if;

    logic       start_wr;
    logic       start_rd;
    logic [7:0] sector_count;
    logic [7:0] byte_in;
    logic       byte_in_stb;
    logic [7:0] byte_out;
    logic       byte_out_valid;
    logic       byte_out_ack;
    logic [15:0] fifo_din;
    logic       fifo_wr;
    logic [15:0] fifo_dout;
    logic       fifo_rd;
    logic       fifo_empty;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        input  start_wr, start_rd, sector_count,
        input  byte_in, byte_in_stb, byte_out_ack,
        input  fifo_dout, fifo_empty,
        output byte_out, byte_out_valid,
        output fifo_din, fifo_wr, fifo_rd,
        output busy, done, overrun
    );

    modport slave (
        output start_wr, start_rd, sector_count,
        output byte_in, byte_in_stb, byte_out_ack,
        output fifo_dout, fifo_empty,
        input  byte_out, byte_out_valid,
        input  fifo_din, fifo_wr, fifo_rd,
        input  busy, done, overrun
    );

endinterface

// File: rtl/ide_fifo_xfer.sv
// IO-side IDE sector FIFO engine: byte stream <-> 16-bit FIFO words,
// with single-cycle rd/wr strobes and exact sector word counting.
module ide_fifo_xfer
    import ide_pkg::*;
#(
    parameter int SECTOR_WORDS = SECTOR_WORDS_DEF,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    ide_fifo_xfer_if.master bus
);

    xfer_state_t      state;
    xfer_state_t      state_nxt;
    logic [CNT_W-1:0] words_left;
    logic [15:0]      din_q;
    logic [15:0]      hold_q;
    logic             overrun_q;
    logic [7:0]       byte_out;

    logic start_any;
    logic start_dir;
    logic load;
    logic last_word;
    logic accepting;
    logic gap;

    assign start_any = bus.start_wr | bus.start_rd;
    assign start_dir = bus.start_wr ? DIR_WR : DIR_RD;
    assign load      = (state == IDLE) && start_any
                     && (bus.sector_count != 8'd0);
    assign last_word = (words_left <= CNT_W'(1));
    assign accepting = (state == WR_LO) || (state == WR_HI);
    assign gap       = (state == WR_GAP) || (state == RD_GAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_any) begin
                    if (bus.sector_count == 8'd0) begin
                        state_nxt = DONE;
                    end else if (start_dir == DIR_WR) begin
                        state_nxt = WR_LO;
                    end else begin
                        state_nxt = RD_CHECK;
                    end
                end
            end
            WR_LO:     if (bus.byte_in_stb) state_nxt = WR_HI;
            WR_HI:     if (bus.byte_in_stb) state_nxt = WR_PULSE;
            WR_PULSE:  state_nxt = WR_GAP;
            WR_GAP:    state_nxt = last_word ? DONE : WR_LO;
            RD_CHECK:  if (!bus.fifo_empty) state_nxt = RD_SETTLE;
            RD_SETTLE: state_nxt = RD_LO;
            RD_LO:     if (bus.byte_out_ack) state_nxt = RD_HI;
            RD_HI:     if (bus.byte_out_ack) state_nxt = RD_PULSE;
            RD_PULSE:  state_nxt = RD_GAP;
            RD_GAP:    state_nxt = last_word ? DONE : RD_CHECK;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FIFO data_out is registered; hold is captured at the end of RD_SETTLE
    always_ff @(posedge clk) begin
        if (reset) begin
            words_left <= '0;
            din_q      <= '0;
            hold_q     <= '0;
            overrun_q  <= 1'b0;
        end else if (clk_en) begin
            if (load) begin
                words_left <= CNT_W'(bus.sector_count)
                            * CNT_W'(SECTOR_WORDS);
            end else if (gap && (words_left != '0)) begin
                words_left <= words_left - CNT_W'(1);
            end
            if ((state == WR_LO) && bus.byte_in_stb) begin
                din_q[7:0] <= bus.byte_in;
            end
            if ((state == WR_HI) && bus.byte_in_stb) begin
                din_q[15:8] <= bus.byte_in;
            end
            if (state == RD_SETTLE) begin
                hold_q <= bus.fifo_dout;
            end
            if (bus.byte_in_stb && !accepting) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        byte_out = 8'h00;
        unique case (1'b1)
            state == RD_LO: byte_out = hold_q[7:0];
            state == RD_HI: byte_out = hold_q[15:8];
            default:        byte_out = 8'h00;
        endcase
    end

    assign bus.byte_out       = byte_out;
    assign bus.byte_out_valid = (state == RD_LO) || (state == RD_HI);
    assign bus.fifo_din       = din_q;
    assign bus.fifo_wr        = (state == WR_PULSE);
    assign bus.fifo_rd        = (state == RD_PULSE);
    assign bus.busy           = (state != IDLE) && (state != DONE);
    assign bus.done           = (state == DONE);
    assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_ide_fifo_xfer.sv
// Bench for ide_fifo_xfer: FIFO model, byte/word scoreboards, directed tests.
module tb_ide_fifo_xfer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_en = 1'b1;

    logic        fifo_clr = 1'b0;
    logic        host_wr = 1'b0;
    logic [15:0] host_data = '0;

    logic [15:0] fq[$];
    logic [15:0] exp_w[$];
    logic [15:0] got_w[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  got_b[$];

    int errs = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int div = 1;
    int ph = 0;

    logic       prev_wr = 1'b0;
    logic       prev_rd = 1'b0;
    logic       have_lo = 1'b0;
    logic [7:0] lo_b = '0;

    ide_fifo_xfer_if bus();

    ide_fifo_xfer #(
        .SECTOR_WORDS(256),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clk_en cycle: step clocks until an enabling edge has passed
    task automatic ecycle();
        logic was_en;
        do begin
            @(posedge clk);
            #1;
            was_en = clk_en;
            ph = (ph + 1) % div;
            clk_en = (ph == 0);
        end while (!was_en);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_cycles);
        bus.byte_in = b;
        bus.byte_in_stb = 1'b1;
        ecycle();
        bus.byte_in_stb = 1'b0;
        if (have_lo) begin
            exp_w.push_back({b, lo_b});
            have_lo = 1'b0;
        end else begin
            lo_b = b;
            have_lo = 1'b1;
        end
        repeat (gap_cycles) ecycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        have_lo = 1'b0;
    endtask

    task automatic start(input logic w, input logic r, input logic [7:0] n);
        bus.sector_count = n;
        bus.start_wr = w;
        bus.start_rd = r;
        ecycle();
        bus.start_wr = 1'b0;
        bus.start_rd = 1'b0;
    endtask

    task automatic run_write();
        int w0;
        int d0;
        got_w.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        start(1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 512; i++) send_byte(8'(i), 3);
        repeat (2) ecycle();
        chk("wr_pulses", wr_cnt - w0, 256);
        chk("wr_done", done_cnt - d0, 1);
        chk("wr_busy_end", bus.busy, 0);
        chk("wr_overrun", bus.overrun, 0);
        chk("wr_exp_left", exp_w.size(), 0);
        chk("wr_first", got_w.size() > 0 ? got_w[0] : 16'h0, 16'h0100);
        chk("wr_last", got_w.size() > 255 ? got_w[255] : 16'h0, 16'hFFFE);
    endtask

    task automatic fifo_flush();
        fifo_clr = 1'b1;
        ecycle();
        fifo_clr = 1'b0;
    endtask

    task automatic run_read();
        int r0;
        int d0;
        fifo_flush();
        for (int n = 0; n < 512; n++) begin
            host_wr = 1'b1;
            host_data = 16'hA500 + 16'(n);
            exp_b.push_back(host_data[7:0]);
            exp_b.push_back(host_data[15:8]);
            ecycle();
        end
        host_wr = 1'b0;
        got_b.delete();
        r0 = rd_cnt;
        d0 = done_cnt;
        bus.byte_out_ack = 1'b1;
        start(1'b0, 1'b1, 8'd2);
        for (int k = 0; k < 4000 && done_cnt == d0; k++) ecycle();
        bus.byte_out_ack = 1'b0;
        ecycle();
        chk("rd_pulses", rd_cnt - r0, 512);
        chk("rd_done", done_cnt - d0, 1);
        chk("rd_exp_left", exp_b.size(), 0);
        chk("rd_nbytes", got_b.size(), 1024);
        chk("rd_b0", got_b.size() > 1 ? got_b[0] : 8'h11, 8'h00);
        chk("rd_b1", got_b.size() > 1 ? got_b[1] : 8'h11, 8'hA5);
        chk("rd_b1022", got_b.size() > 1023 ? got_b[1022] : 8'h11, 8'hFF);
        chk("rd_b1023", got_b.size() > 1023 ? got_b[1023] : 8'h11, 8'hA6);
        chk("rd_fifo_drained", bus.fifo_empty, 1);
        chk("rd_busy_end", bus.busy, 0);
    endtask

    // FIFO model: registered data_out, pointer moves after a strobe
    initial begin
        logic [15:0] d;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout = '0;
        forever begin
            @(posedge clk);
            if (clk_en) begin
                if (fifo_clr) begin
                    fq.delete();
                end else begin
                    d = (fq.size() != 0) ? fq[0] : bus.fifo_dout;
                    if (bus.fifo_rd && fq.size() != 0) void'(fq.pop_front());
                    if (bus.fifo_wr) fq.push_back(bus.fifo_din);
                    if (host_wr) fq.push_back(host_data);
                    bus.fifo_dout <= d;
                end
                bus.fifo_empty <= (fq.size() == 0);
            end
        end
    end

    // Compare process: once per clk_en cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wr = 1'b0;
                prev_rd = 1'b0;
            end else if (clk_en) begin
                if (bus.fifo_wr) begin
                    chk("wr_consec", prev_wr, 0);
                    chk("wr_rd_excl", bus.fifo_rd, 0);
                    chk("wr_busy", bus.busy, 1);
                    chk("wr_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0)
                        chk("wr_word", bus.fifo_din, exp_w.pop_front());
                    got_w.push_back(bus.fifo_din);
                    wr_cnt++;
                end
                if (bus.fifo_rd) begin
                    chk("rd_consec", prev_rd, 0);
                    chk("rd_busy", bus.busy, 1);
                    rd_cnt++;
                end
                if (bus.byte_out_valid && bus.byte_out_ack) begin
                    chk("rd_expected", exp_b.size() != 0, 1);
                    if (exp_b.size() != 0)
                        chk("rd_byte", bus.byte_out, exp_b.pop_front());
                    got_b.push_back(bus.byte_out);
                end
                if (bus.done) begin
                    chk("done_busy", bus.busy, 0);
                    done_cnt++;
                end
                prev_wr = bus.fifo_wr;
                prev_rd = bus.fifo_rd;
            end
        end
    end

    initial begin
        int v;
        int w0;
        int r0;
        int d0;
        bus.start_wr = 1'b0;
        bus.start_rd = 1'b0;
        bus.sector_count = 8'd0;
        bus.byte_in = 8'd0;
        bus.byte_in_stb = 1'b0;
        bus.byte_out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wr", bus.fifo_wr, 0);
        chk("rst_rd", bus.fifo_rd, 0);
        chk("rst_valid", bus.byte_out_valid, 0);
        chk("rst_bout", bus.byte_out, 0);
        chk("rst_din", bus.fifo_din, 0);
        chk("rst_overrun", bus.overrun, 0);

        // zero sectors: immediate done, no FIFO access
        r0 = rd_cnt;
        start(1'b0, 1'b1, 8'd0);
        chk("zero_done", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        chk("zero_rd", bus.fifo_rd, 0);
        ecycle();
        chk("zero_done_end", bus.done, 0);
        chk("zero_busy_end", bus.busy, 0);
        chk("zero_rd_cnt", rd_cnt - r0, 0);

        run_write();
        run_read();

        // empty FIFO: nothing presented until a word lands and settles
        fifo_flush();
        r0 = rd_cnt;
        start(1'b0, 1'b1, 8'd1);
        v = 0;
        for (int k = 0; k < 50; k++) begin
            ecycle();
            if (bus.byte_out_valid) v++;
        end
        chk("empty_no_valid", v, 0);
        exp_b.push_back(8'h34);
        exp_b.push_back(8'h12);
        host_wr = 1'b1;
        host_data = 16'h1234;
        ecycle();
        host_wr = 1'b0;
        chk("late_check_v", bus.byte_out_valid, 0);
        ecycle();
        chk("late_settle_v", bus.byte_out_valid, 0);
        ecycle();
        chk("late_lo_v", bus.byte_out_valid, 1);
        chk("late_lo", bus.byte_out, 8'h34);
        bus.byte_out_ack = 1'b1;
        ecycle();
        chk("late_hi_v", bus.byte_out_valid, 1);
        chk("late_hi", bus.byte_out, 8'h12);
        ecycle();
        bus.byte_out_ack = 1'b0;
        chk("late_pulse", bus.fifo_rd, 1);
        ecycle();
        chk("late_gap", bus.fifo_rd, 0);
        chk("late_rd_cnt", rd_cnt - r0, 1);
        chk("late_exp_left", exp_b.size(), 0);
        do_reset();

        // byte arriving during the write strobe is dropped
        start(1'b1, 1'b0, 8'd1);
        send_byte(8'h11, 3);
        send_byte(8'h22, 0);
        bus.byte_in = 8'hEE;
        bus.byte_in_stb = 1'b1;
        ecycle();
        bus.byte_in_stb = 1'b0;
        chk("ovr_set", bus.overrun, 1);
        ecycle();
        send_byte(8'h33, 3);
        send_byte(8'h44, 3);
        chk("ovr_sticky", bus.overrun, 1);
        chk("ovr_next_word", got_w.size() > 0 ? got_w[got_w.size()-1] : 16'h0,
            16'h4433);
        chk("ovr_exp_left", exp_w.size(), 0);
        do_reset();
        chk("ovr_cleared", bus.overrun, 0);
        chk("ovr_rst_busy", bus.busy, 0);

        // reset in the middle of a write, then a clean transfer
        start(1'b1, 1'b0, 8'd1);
        send_byte(8'hA1, 3);
        send_byte(8'hB2, 3);
        send_byte(8'hC3, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_wr", bus.fifo_wr, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_din", bus.fifo_din, 0);
        reset = 1'b0;
        have_lo = 1'b0;
        chk("mid_exp_left", exp_w.size(), 0);
        run_write();

        // simultaneous starts pick write; starts while busy are ignored
        w0 = wr_cnt;
        r0 = rd_cnt;
        d0 = done_cnt;
        start(1'b1, 1'b1, 8'd1);
        chk("both_busy", bus.busy, 1);
        start(1'b0, 1'b1, 8'd0);
        chk("busy_ign_done", bus.done, 0);
        send_byte(8'h5A, 3);
        send_byte(8'hC3, 3);
        chk("both_wr_cnt", wr_cnt - w0, 1);
        chk("both_rd_cnt", rd_cnt - r0, 0);
        chk("both_done_cnt", done_cnt - d0, 0);
        chk("both_word", got_w.size() > 0 ? got_w[got_w.size()-1] : 16'h0,
            16'hC35A);
        do_reset();

        // stretched clock enable: same results
        div = 3;
        run_write();
        run_read();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
